// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Pipelined immediate generator for the decode stage. Extracts the
//            I/S/B/J/U/CSR-zimm immediate from an instruction word, extends it
//            to XLEN bits and delivers it one cycle later from a registered
//            output with a one-entry skid buffer. A tag rides along with each
//            word. Flush discards everything held or arriving that cycle.
// Options  : IMMGEN_AUTODEC_EN - derive the format from the opcode, ignoring sel
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      ins,
  input  logic [2:0]       sel,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  // Internal format codes; the non-autodecode build uses sel directly, so the
  // codes match the sel encoding and 6/7 fall into the illegal default.
  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_J = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_Z = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  logic [2:0]      w_fmt;
  logic [31:0]     w_imm32;
  logic            w_illegal;
  logic [XLEN-1:0] w_imm;
  logic            w_accept;
  logic            w_pop;

  // Main output register (M) and skid register (K)
  logic             m_valid_q, m_valid_d;
  logic [XLEN-1:0]  m_imm_q,   m_imm_d;
  logic [TAG_W-1:0] m_tag_q,   m_tag_d;
  logic             m_ill_q,   m_ill_d;
  logic             k_valid_q, k_valid_d;
  logic [XLEN-1:0]  k_imm_q,   k_imm_d;
  logic [TAG_W-1:0] k_tag_q,   k_tag_d;
  logic             k_ill_q,   k_ill_d;

`ifdef IMMGEN_AUTODEC_EN
  logic w_sel_unused;
  assign w_sel_unused = ^sel;

  // Format chosen from the major opcode; SYSTEM splits on funct3[2] (zimm forms)
  always_comb begin
    w_fmt = FMT_X;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: w_fmt = FMT_I;
      7'b0100011:                                     w_fmt = FMT_S;
      7'b1100011:                                     w_fmt = FMT_B;
      7'b1101111:                                     w_fmt = FMT_J;
      7'b0110111, 7'b0010111:                         w_fmt = FMT_U;
      7'b1110011:                                     w_fmt = ins[14] ? FMT_Z : FMT_I;
      default:                                        w_fmt = FMT_X;
    endcase
  end
`else
  logic w_opcode_unused;
  assign w_opcode_unused = ^ins[6:0];

  // Format taken straight from the select input
  always_comb begin
    w_fmt = sel;
  end
`endif

  // Field extraction to a 32-bit value already sign-extended from the format's
  // top bit; zimm has a zero top bit so the later XLEN extension keeps it unsigned.
  always_comb begin
    w_imm32   = 32'd0;
    w_illegal = 1'b0;
    case (w_fmt)
      FMT_I:   w_imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   w_imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   w_imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_J:   w_imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_U:   w_imm32 = {ins[31:12], 12'd0};
      FMT_Z:   w_imm32 = {27'd0, ins[19:15]};
      default: w_illegal = 1'b1;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_ext_wide
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_ext_narrow
      assign w_imm = w_imm32[XLEN-1:0];
    end
  endgenerate

  assign w_accept = in_valid && !k_valid_q;
  assign w_pop    = m_valid_q && out_ready;

  // Next-state for the M/K pair: pop refills M from K (or the input), a
  // non-popped accept lands in M if empty, otherwise in K.
  always_comb begin
    m_valid_d = m_valid_q;
    m_imm_d   = m_imm_q;
    m_tag_d   = m_tag_q;
    m_ill_d   = m_ill_q;
    k_valid_d = k_valid_q;
    k_imm_d   = k_imm_q;
    k_tag_d   = k_tag_q;
    k_ill_d   = k_ill_q;
    if (flush) begin
      m_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (w_pop) begin
      if (k_valid_q) begin
        m_valid_d = 1'b1;
        m_imm_d   = k_imm_q;
        m_tag_d   = k_tag_q;
        m_ill_d   = k_ill_q;
        k_valid_d = 1'b0;
      end else if (w_accept) begin
        m_valid_d = 1'b1;
        m_imm_d   = w_imm;
        m_tag_d   = in_tag;
        m_ill_d   = w_illegal;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      if (!m_valid_q) begin
        m_valid_d = 1'b1;
        m_imm_d   = w_imm;
        m_tag_d   = in_tag;
        m_ill_d   = w_illegal;
      end else begin
        k_valid_d = 1'b1;
        k_imm_d   = w_imm;
        k_tag_d   = in_tag;
        k_ill_d   = w_illegal;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_imm_q   <= '0;
      m_tag_q   <= '0;
      m_ill_q   <= 1'b0;
      k_valid_q <= 1'b0;
      k_imm_q   <= '0;
      k_tag_q   <= '0;
      k_ill_q   <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_imm_q   <= m_imm_d;
      m_tag_q   <= m_tag_d;
      m_ill_q   <= m_ill_d;
      k_valid_q <= k_valid_d;
      k_imm_q   <= k_imm_d;
      k_tag_q   <= k_tag_d;
      k_ill_q   <= k_ill_d;
    end
  end

  assign in_ready    = !k_valid_q;
  assign out_valid   = m_valid_q;
  assign out_imm     = m_imm_q;
  assign out_tag     = m_tag_q;
  assign out_illegal = m_ill_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Self-checking bench for imm_gen_pipe (XLEN=32 and XLEN=64 copies
//            driven in lockstep). Table of vectors plus backpressure, flush and
//            mid-transfer reset sequences; results checked through a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

  localparam int TW = 16;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   ins = 32'd0;
  logic [2:0]    sel = 3'd0;
  logic [TW-1:0] in_tag = '0;

  logic          in_ready, out_valid, out_illegal;
  logic [63:0]   out_imm;
  logic [TW-1:0] out_tag;
  logic          in_ready32, out_valid32, out_illegal32;
  logic [31:0]   out_imm32;
  logic [TW-1:0] out_tag32;

  logic [63:0]   cur_imm = 64'd0;
  logic          cur_ill = 1'b0;

  typedef struct {
    logic [63:0]   imm;
    logic [TW-1:0] tag;
    logic          ill;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  sel;
    logic [63:0] imm;
    logic        ill;
  } vec_t;
  vec_t vt[$];

  int checks = 0;
  int errors = 0;

  imm_gen_pipe #(.XLEN(64), .TAG_W(TW)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ins(ins), .sel(sel), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(TW)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .ins(ins), .sel(sel), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] s,
                       input logic [TW-1:0] t, input logic [63:0] ei, input logic eil);
    in_valid = v;
    ins      = i;
    sel      = s;
    in_tag   = t;
    cur_imm  = ei;
    cur_ill  = eil;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs are stable from posedge+1 until the next posedge, so the
  // handshake that will occur at the coming edge is visible at the negedge.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n || flush) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pop_qsize", 64'(sbq.size()), 64'd1);
        end else begin
          e = sbq.pop_front();
          chk("sb_imm64", out_imm, e.imm);
          chk("sb_imm32", {32'd0, out_imm32}, {32'd0, e.imm[31:0]});
          chk("sb_tag64", {48'd0, out_tag}, {48'd0, e.tag});
          chk("sb_tag32", {48'd0, out_tag32}, {48'd0, e.tag});
          chk("sb_ill64", {63'd0, out_illegal}, {63'd0, e.ill});
          chk("sb_ill32", {63'd0, out_illegal32}, {63'd0, e.ill});
          chk("sb_valid32", {63'd0, out_valid32}, 64'd1);
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back('{imm: cur_imm, tag: in_tag, ill: cur_ill});
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
`ifdef IMMGEN_AUTODEC_EN
    vt.push_back('{32'hFE000CE3, 3'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0});
    vt.push_back('{32'h0000007F, 3'd0, 64'd0,                  1'b1});
    vt.push_back('{32'hFFF00093, 3'd3, ALL1,                   1'b0});
    vt.push_back('{32'h0007D073, 3'd0, 64'h0000_0000_0000_000F, 1'b0});
    vt.push_back('{32'h80002073, 3'd5, 64'hFFFF_FFFF_FFFF_F800, 1'b0});
    vt.push_back('{32'h800000B7, 3'd0, 64'hFFFF_FFFF_8000_0000, 1'b0});
    vt.push_back('{32'hFE20AE23, 3'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
    vt.push_back('{32'h0010006F, 3'd0, 64'h0000_0000_0000_0800, 1'b0});
    vt.push_back('{32'h00000033, 3'd0, 64'd0,                  1'b1});
`else
    vt.push_back('{32'hFFF00093, 3'd0, ALL1,                   1'b0});
    vt.push_back('{32'h7FF00093, 3'd0, 64'h0000_0000_0000_07FF, 1'b0});
    vt.push_back('{32'hFE20AE23, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
    vt.push_back('{32'h00000F80, 3'd1, 64'h0000_0000_0000_001F, 1'b0});
    vt.push_back('{32'hFE000CE3, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0});
    vt.push_back('{32'h0010006F, 3'd3, 64'h0000_0000_0000_0800, 1'b0});
    vt.push_back('{32'h8000006F, 3'd3, 64'hFFFF_FFFF_FFF0_0000, 1'b0});
    vt.push_back('{32'h0007D073, 3'd5, 64'h0000_0000_0000_000F, 1'b0});
    vt.push_back('{32'hFFFFFFFF, 3'd5, 64'h0000_0000_0000_001F, 1'b0});
    vt.push_back('{32'h800000B7, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b0});
    vt.push_back('{32'h12345037, 3'd4, 64'h0000_0000_1234_5000, 1'b0});
    vt.push_back('{32'h00000013, 3'd6, 64'd0,                  1'b1});
    vt.push_back('{32'hFFFFFFFF, 3'd7, 64'd0,                  1'b1});
`endif

    // Reset
    rst_n = 1'b0;
    repeat (3) step;
    chk("rst_out_valid",   {63'd0, out_valid},   64'd0);
    chk("rst_out_imm",     out_imm,              64'd0);
    chk("rst_out_imm32",   {32'd0, out_imm32},   64'd0);
    chk("rst_out_tag",     {48'd0, out_tag},     64'd0);
    chk("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
    rst_n = 1'b1;
    step;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Streaming table: one-cycle latency, one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      drive(1'b1, vt[i].ins, vt[i].sel, TW'(100 + i), vt[i].imm, vt[i].ill);
      chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
      step;
      chk("stream_out_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_out_imm",   out_imm, vt[i].imm);
      chk("stream_out_tag",   {48'd0, out_tag}, 64'(100 + i));
    end
    drive(1'b0, 32'd0, 3'd0, '0, 64'd0, 1'b0);
    step;
    chk("stream_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure: tags 1,2,3 offered while the consumer stalls
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd0, TW'(1), ALL1, 1'b0);
    step;
    chk("bp_m_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_m_tag1",  {48'd0, out_tag},   64'd1);
    drive(1'b1, 32'hFFF00093, 3'd0, TW'(2), ALL1, 1'b0);
    step;
    chk("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_hold_tag1",     {48'd0, out_tag},  64'd1);
    drive(1'b1, 32'hFFF00093, 3'd0, TW'(3), ALL1, 1'b0);
    step;
    chk("bp_still_full",   {63'd0, in_ready},   64'd0);
    chk("bp_hold_tag1_b",  {48'd0, out_tag},    64'd1);
    chk("bp_hold_imm",     out_imm,             ALL1);
    chk("bp_tag3_refused", 64'(sbq.size()),     64'd2);
    out_ready = 1'b1;
    step;
    chk("bp_tag2_next",   {48'd0, out_tag},   64'd2);
    chk("bp_valid_2",     {63'd0, out_valid}, 64'd1);
    chk("bp_ready_again", {63'd0, in_ready},  64'd1);
    step;
    chk("bp_tag3_next", {48'd0, out_tag},   64'd3);
    chk("bp_valid_3",   {63'd0, out_valid}, 64'd1);
    drive(1'b0, 32'd0, 3'd0, '0, 64'd0, 1'b0);
    step;
    chk("bp_empty",       {63'd0, out_valid}, 64'd0);
    chk("bp_sb_drained",  64'(sbq.size()),    64'd0);

    // Flush while FULL with a word being offered
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd0, TW'(10), ALL1, 1'b0);
    step;
    drive(1'b1, 32'hFFF00093, 3'd0, TW'(11), ALL1, 1'b0);
    step;
    chk("fl_full", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 32'hFFF00093, 3'd0, TW'(12), ALL1, 1'b0);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_in_ready",  {63'd0, in_ready},  64'd1);
    drive(1'b0, 32'd0, 3'd0, '0, 64'd0, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step;
      chk("fl_nothing_reappears", {63'd0, out_valid}, 64'd0);
    end

    // Reset asserted while a result is held
    out_ready = 1'b0;
    drive(1'b1, 32'h800000B7, 3'd4, TW'(20), 64'hFFFF_FFFF_8000_0000, 1'b0);
    step;
    chk("mr_loaded", {63'd0, out_valid}, 64'd1);
    drive(1'b0, 32'd0, 3'd0, '0, 64'd0, 1'b0);
    rst_n = 1'b0;
    step;
    chk("mr_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mr_out_imm",   out_imm,            64'd0);
    chk("mr_out_tag",   {48'd0, out_tag},   64'd0);
    rst_n = 1'b1;
    step;
    chk("mr_in_ready",  {63'd0, in_ready},  64'd1);
    chk("mr_sb_empty",  64'(sbq.size()),    64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. It accepts an instruction word plus a format select over a valid/ready handshake and extracts the I/S/B/J/U/CSR-zimm immediate. The immediate is extended to XLEN bits and returned one cycle later through a registered output with a skid buffer. It replaces the combinational immediate path between fetch/decode and the ALU operand mux, adds a flush input for branch redirect, and carries a sideband tag (typically the PC).

## Interface
Parameters:
- XLEN, 32: output width; legal values are 32 and 64.
- TAG_W, 32: width of the passthrough tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept; registered.
- ins  in  32  instruction word.
- sel  in  3  format: 0=I, 1=S, 2=B, 3=J, 4=U, 5=Z (CSR zimm), 6/7 reserved.
- in_tag  in  TAG_W  sideband carried with the word.
- flush  in  1  discard all held and incoming data.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of the result.
- out_illegal  out  1  sel was reserved; out_imm=0.

## Operation
- Extraction:
  - I = sext(ins[31:20]).
  - S = sext({ins[31:25],ins[11:7]}).
  - B = sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0}).
  - J = sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0}).
  - U = sext({ins[31:12],12'b0}); with XLEN=64, bits 63:32 copy ins[31].
  - Z = zext(ins[19:15]).
- Sign extension is always from the format's top bit to XLEN.
- Reserved sel: out_imm=0 and out_illegal=1. The result is still delivered; it is not dropped.
- Storage: a main output register (M) and one skid register (K). Each holds {imm, tag, illegal, valid}.
- in_ready = !K.valid.
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Transitions (computation happens at the input, before registering):
  - EMPTY (M, K invalid): accept loads M.
  - ONE (M valid): pop without accept goes to EMPTY. Accept with pop reloads M. Accept without pop loads K and goes to FULL.
  - FULL: in_ready=0. Pop moves K into M and goes to ONE.
- Ordering is strictly FIFO. No result is ever dropped or duplicated except by flush.
- flush has priority over everything. Next cycle M.valid=K.valid=0, and any word accepted in the flush cycle is discarded.
- Reset: out_valid=0, out_imm=0, out_tag=0, out_illegal=0. in_ready is 1 from the first cycle after reset.

## Timing
- Latency: 1 cycle from accept to out_valid (EMPTY case).
- Throughput: 1 result per cycle while out_ready=1.
- out_* are driven directly from M registers, with no combinational path from inputs.
- in_ready depends only on registered state, never on out_ready in the same cycle.
- While out_valid=1 and out_ready=0, out_imm, out_tag and out_illegal are held stable.
- Reset asserted mid-transfer clears M and K on the next edge, the same as flush.
- Simultaneous pop+accept in ONE sustains full throughput with no bubble.

## Configuration
- IMMGEN_AUTODEC_EN defined: sel is ignored, and the format is derived from ins[6:0]:
  - 0000011, 0010011, 0011011, 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 1101111 → J.
  - 0110111, 0010111 → U.
  - 1110011 → Z if ins[14]=1, else I.
  - Any other opcode → illegal.
- IMMGEN_AUTODEC_EN undefined: the format is taken from sel only. The sel port exists in both builds.

## Test plan
- Reset then XLEN=32, sel=0, ins=0xFFF00093 → in_ready=1; one cycle later out_valid=1, out_imm=0xFFFFFFFF.
- sel=1 ins=0xFE20AE23 → 0xFFFFFFFC. sel=2 ins=0xFE000CE3 → 0xFFFFFFF8. sel=3 ins=0x0010006F → 0x00000800. sel=5 ins=0x0007D073 → 0x0000000F.
- XLEN=64, sel=4, ins=0x800000B7 → 0xFFFFFFFF80000000. sel=6 → out_imm=0, out_illegal=1.
- Backpressure: out_ready=0 while 3 words (tags 1,2,3) are offered back-to-back:
  - Tag 1 is held in M, tag 2 goes to K, in_ready=0, tag 3 is not accepted.
  - Then out_ready=1 → tags delivered 1,2,3 in consecutive order, none lost.
- Flush in FULL with in_valid=1 → next cycle out_valid=0 and in_ready=1, and the flushed words never appear.
- IMMGEN_AUTODEC_EN build: sel=0 with ins=0xFE000CE3 → 0xFFFFFFF8 (B chosen from opcode). ins=0x0000007F → out_illegal=1.
